// File: rtl/unit_output_collector.sv
// unit_output_collector
//   Round-robin collector sitting downstream of N_UNITS unit output buffers.
//   It picks one non-empty unit and pulses that unit's read request. It then
//   checks the 2'b11 header symbol, deserialises OUT_N_WORDS 2-bit payload
//   symbols into 16-bit words and writes a tagged header word followed by
//   the payload words into the output FIFO.
//
// Ports
//   clk         single clock, shared with the unit read side
//   rst_n       asynchronous reset, active low
//   unit_dout   unit i symbol on [2*i+1:2*i] (registered in the unit)
//   unit_empty  1 = unit i has no packet ready
//   unit_rd_en  one-cycle read request to unit i (at most one bit high)
//   fifo_full   1 = output FIFO cannot take a whole packet (sampled in IDLE only)
//   dout        output word
//   wr_en       dout valid, write strobe to the FIFO
//   err         sticky: a bad header was seen
//   err_unit    unit index of the first bad header
//   dbg_state   current FSM state (state_t encoding)
//
// Handshake: there is no back-pressure once a packet has started. fifo_full
// low in IDLE promises room for a whole packet. wr_en is a pure write strobe
// and dout is valid only in cycles where wr_en is high.
module unit_output_collector #(
    parameter int         N_UNITS     = 4,
    parameter int         OUT_N_WORDS = 288,
    parameter logic [7:0] HDR_TAG     = 8'hD5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2*N_UNITS-1:0]   unit_dout,
    input  logic [N_UNITS-1:0]     unit_empty,
    output logic [N_UNITS-1:0]     unit_rd_en,
    input  logic                   fifo_full,
    output logic [15:0]            dout,
    output logic                   wr_en,
    output logic                   err,
    output logic [7:0]             err_unit,
    output logic [2:0]             dbg_state
);

    localparam int PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int CNT_W = $clog2(OUT_N_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_WAIT   = 3'd2,
        S_HDR    = 3'd3,
        S_DATA   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [15:0]        shift_q, shift_d;
    logic [N_UNITS-1:0] rd_en_q, rd_en_d;
    logic [15:0]        dout_q, dout_d;
    logic               wr_en_q, wr_en_d;
    logic               err_q, err_d;
    logic [7:0]         err_unit_q, err_unit_d;
    logic [1:0]         sym;

    // Round-robin successor with explicit wrap so non power-of-two
    // unit counts never visit an unused index.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_UNITS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Symbol mux driven by the selected unit's registered output.
    always_comb begin
        sym = 2'b00;
        for (int i = 0; i < N_UNITS; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                sym = unit_dout[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sym_cnt_d  = sym_cnt_q;
        shift_d    = shift_q;
        rd_en_d    = '0;
        dout_d     = dout_q;
        wr_en_d    = 1'b0;
        err_d      = err_q;
        err_unit_d = err_unit_q;

        case (state_q)
            S_IDLE: begin
                // One unit examined per cycle; the pointer only moves on when
                // the current unit cannot be served.
                if (!unit_empty[ptr_q] && !fifo_full) begin
                    rd_en_d = {{(N_UNITS-1){1'b0}}, 1'b1} << ptr_q;
                    state_d = S_RD_REQ;
                end else begin
                    ptr_d = ptr_inc(ptr_q);
                end
            end
            S_RD_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_HDR;
            end
            S_HDR: begin
                if (sym == 2'b11) begin
                    dout_d    = {HDR_TAG, 8'(ptr_q)};
                    wr_en_d   = 1'b1;
                    sym_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    err_d = 1'b1;
                    if (!err_q) begin
                        err_unit_d = 8'(ptr_q);
                    end
                    ptr_d   = ptr_inc(ptr_q);
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                // LSB-first: after 8 shifts symbol k of the word sits in [2k+1:2k].
                shift_d   = {sym, shift_q[15:2]};
                sym_cnt_d = sym_cnt_q + 1'b1;
                if (sym_cnt_q[2:0] == 3'd7) begin
                    dout_d  = shift_d;
                    wr_en_d = 1'b1;
                end
                if (sym_cnt_q == CNT_W'(OUT_N_WORDS - 1)) begin
                    ptr_d   = ptr_inc(ptr_q);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            sym_cnt_q  <= '0;
            shift_q    <= '0;
            rd_en_q    <= '0;
            dout_q     <= '0;
            wr_en_q    <= 1'b0;
            err_q      <= 1'b0;
            err_unit_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sym_cnt_q  <= sym_cnt_d;
            shift_q    <= shift_d;
            rd_en_q    <= rd_en_d;
            dout_q     <= dout_d;
            wr_en_q    <= wr_en_d;
            err_q      <= err_d;
            err_unit_q <= err_unit_d;
        end
    end

    assign unit_rd_en = rd_en_q;
    assign dout       = dout_q;
    assign wr_en      = wr_en_q;
    assign err        = err_q;
    assign err_unit   = err_unit_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_unit_output_collector.sv
// Bench for unit_output_collector: dut_a uses the default packet length and
// dut_b uses OUT_N_WORDS=16. Both share clock and reset. A behavioural unit
// model answers each read request with a header two edges later, then one
// payload symbol per cycle, where symbol k = (k + off) % 4.
module tb_unit_output_collector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT side signals
    logic [7:0]  ud [2];
    logic [3:0]  emp [2];
    logic [3:0]  rd_a, rd_b;
    logic        full_a, full_b;
    logic [15:0] da, db;
    logic        wa, wb, err_a, err_b;
    logic [7:0]  eu_a, eu_b;
    logic [2:0]  dbg_a, dbg_b;

    unit_output_collector #(.N_UNITS(4), .OUT_N_WORDS(288), .HDR_TAG(8'hD5)) dut_a (
        .clk(clk), .rst_n(rst_n), .unit_dout(ud[0]), .unit_empty(emp[0]),
        .unit_rd_en(rd_a), .fifo_full(full_a), .dout(da), .wr_en(wa),
        .err(err_a), .err_unit(eu_a), .dbg_state(dbg_a)
    );

    unit_output_collector #(.N_UNITS(4), .OUT_N_WORDS(16), .HDR_TAG(8'hD5)) dut_b (
        .clk(clk), .rst_n(rst_n), .unit_dout(ud[1]), .unit_empty(emp[1]),
        .unit_rd_en(rd_b), .fifo_full(full_b), .dout(db), .wr_en(wb),
        .err(err_b), .err_unit(eu_b), .dbg_state(dbg_b)
    );

    // Unit model state: req written by the stimulus, taken by the model.
    int         req   [2][4];
    int         taken [2][4];
    int         pos   [2][4];
    int         off   [2][4];
    logic [1:0] hdr   [2][4];
    logic [3:0] rdv   [2];

    assign rdv[0] = rd_a;
    assign rdv[1] = rd_b;

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            emp[g] = '0;
            for (int i = 0; i < 4; i++) begin
                emp[g][i] = (req[g][i] == taken[g][i]);
            end
        end
    end

    // Units reset together with the collector and drop pending packets.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < 2; g++) begin
                ud[g] <= '0;
                for (int i = 0; i < 4; i++) begin
                    pos[g][i]   <= -1;
                    taken[g][i] <= req[g][i];
                end
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                for (int i = 0; i < 4; i++) begin
                    if (rdv[g][i]) begin
                        pos[g][i]   <= 0;
                        taken[g][i] <= taken[g][i] + 1;
                    end else if (pos[g][i] == 0) begin
                        ud[g][2*i +: 2] <= hdr[g][i];
                        pos[g][i]       <= 1;
                    end else if (pos[g][i] > 0) begin
                        ud[g][2*i +: 2] <= 2'((pos[g][i] - 1 + off[g][i]) % 4);
                        pos[g][i]       <= pos[g][i] + 1;
                    end
                end
            end
        end
    end

    // Output capture, sampled on the falling edge.
    logic [15:0] got0 [$];
    logic [15:0] got1 [$];
    int          got0_t [$];
    int          got1_t [$];
    logic [3:0]  rq0 [$];
    logic [3:0]  rq1 [$];
    int          rq0_t [$];
    int          rq1_t [$];
    int          bad_rd = 0;

    always @(negedge clk) begin
        if (wa === 1'b1) begin got0.push_back(da); got0_t.push_back(cyc); end
        if (wb === 1'b1) begin got1.push_back(db); got1_t.push_back(cyc); end
        if (rd_a !== 4'b0000) begin
            rq0.push_back(rd_a); rq0_t.push_back(cyc);
            if ($countones(rd_a) != 1) bad_rd++;
        end
        if (rd_b !== 4'b0000) begin
            rq1.push_back(rd_b); rq1_t.push_back(cyc);
            if ($countones(rd_b) != 1) bad_rd++;
        end
    end

    // Per-test views into the capture queues.
    int gb0 = 0, gb1 = 0, rb0 = 0, rb1 = 0;

    function automatic int n_w(input int g);
        return (g == 0) ? got0.size() - gb0 : got1.size() - gb1;
    endfunction
    function automatic int n_r(input int g);
        return (g == 0) ? rq0.size() - rb0 : rq1.size() - rb1;
    endfunction
    function automatic logic [15:0] w0(input int k); return got0[gb0 + k]; endfunction
    function automatic logic [15:0] w1(input int k); return got1[gb1 + k]; endfunction
    function automatic int t0(input int k); return got0_t[gb0 + k]; endfunction
    function automatic int t1(input int k); return got1_t[gb1 + k]; endfunction
    function automatic logic [3:0] r0(input int k); return rq0[rb0 + k]; endfunction
    function automatic logic [3:0] r1(input int k); return rq1[rb1 + k]; endfunction
    function automatic int rt0(input int k); return rq0_t[rb0 + k]; endfunction

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        gb0 = got0.size(); gb1 = got1.size();
        rb0 = rq0.size();  rb1 = rq1.size();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mark();
    endtask

    // Bounded wait on a capture count; an expired budget fails the check.
    task automatic wait_for(input int g, input bit is_rd, input int n, input int budget, input string tag);
        int k = 0;
        while (((is_rd ? n_r(g) : n_w(g)) < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(is_rd ? n_r(g) : n_w(g)), 32'(n));
    endtask

    logic [15:0] exp_q [$];
    int c, r, idx, k;

    initial begin
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 4; i++) begin
                req[g][i] = 0;
                off[g][i] = 0;
                hdr[g][i] = 2'b11;
            end
        end
        off[1][1] = 1;
        full_a = 1'b0;
        full_b = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wa), 32'd0);
        check("rst_rd_en", 32'(rd_a), 32'd0);
        check("rst_dout", 32'(da), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_err_unit", 32'(eu_a), 32'd0);
        check("rst_state", 32'(dbg_a), 32'd0);
        check("rst_b_wr_en", 32'(wb), 32'd0);
        rst_n = 1'b1;
        mark();

        // 1: only unit 2 non-empty
        req[0][2] += 1;
        wait_for(0, 0, 37, 400, "t1_word_count");
        repeat (20) @(negedge clk);
        check("t1_words_total", 32'(n_w(0)), 32'd37);
        check("t1_rd_pulses", 32'(n_r(0)), 32'd1);
        check("t1_rd_value", 32'(r0(0)), 32'h4);
        check("t1_header", 32'(w0(0)), 32'hD502);
        for (int j = 1; j <= 36; j++) check($sformatf("t1_payload_%0d", j), 32'(w0(j)), 32'hE4E4);
        check("t1_hdr_latency", 32'(t0(0) - rt0(0)), 32'd3);
        check("t1_first_word_gap", 32'(t0(1) - t0(0)), 32'd8);
        check("t1_last_word_gap", 32'(t0(36) - t0(0)), 32'd288);
        check("t1_err", 32'(err_a), 32'd0);

        // 2: all units busy, expect order 0,1,2,3,0
        apply_reset();
        req[0][0] += 2; req[0][1] += 1; req[0][2] += 1; req[0][3] += 1;
        wait_for(0, 0, 185, 1700, "t2_word_count");
        repeat (20) @(negedge clk);
        check("t2_words_total", 32'(n_w(0)), 32'd185);
        check("t2_rd_pulses", 32'(n_r(0)), 32'd5);
        check("t2_rd_0", 32'(r0(0)), 32'h1);
        check("t2_rd_1", 32'(r0(1)), 32'h2);
        check("t2_rd_2", 32'(r0(2)), 32'h4);
        check("t2_rd_3", 32'(r0(3)), 32'h8);
        check("t2_rd_4", 32'(r0(4)), 32'h1);
        check("t2_hdr_0", 32'(w0(0)), 32'hD500);
        check("t2_hdr_1", 32'(w0(37)), 32'hD501);
        check("t2_hdr_2", 32'(w0(74)), 32'hD502);
        check("t2_hdr_3", 32'(w0(111)), 32'hD503);
        check("t2_hdr_4", 32'(w0(148)), 32'hD500);
        check("t2_last_payload", 32'(w0(184)), 32'hE4E4);

        // 3: fifo_full blocks, then mid-packet full is ignored
        full_a = 1'b1;
        apply_reset();
        req[0][0] += 1; req[0][1] += 1; req[0][2] += 1; req[0][3] += 1;
        repeat (20) @(negedge clk);
        check("t3_no_rd_while_full", 32'(n_r(0)), 32'd0);
        full_a = 1'b0;
        c = cyc;
        wait_for(0, 1, 1, 10, "t3_rd_after_release");
        check("t3_rd_latency_ok", 32'((rt0(0) - c) <= 5), 32'd1);
        repeat (50) @(negedge clk);
        full_a = 1'b1;
        wait_for(0, 0, 37, 400, "t3_word_count");
        idx = 0;
        for (int i = 0; i < 4; i++) if (r0(0) == 4'(1 << i)) idx = i;
        check("t3_header", 32'(w0(0)), 32'({8'hD5, 8'(idx)}));
        repeat (30) @(negedge clk);
        check("t3_words_total", 32'(n_w(0)), 32'd37);
        check("t3_no_new_rd", 32'(n_r(0)), 32'd1);
        full_a = 1'b0;

        // 4: bad headers, sticky error with first unit kept
        apply_reset();
        hdr[0][1] = 2'b10;
        req[0][1] += 1; req[0][2] += 1;
        wait_for(0, 0, 37, 500, "t4_word_count");
        check("t4_err", 32'(err_a), 32'd1);
        check("t4_err_unit", 32'(eu_a), 32'd1);
        check("t4_rd_pulses", 32'(n_r(0)), 32'd2);
        check("t4_rd_0", 32'(r0(0)), 32'h2);
        check("t4_rd_1", 32'(r0(1)), 32'h4);
        check("t4_header", 32'(w0(0)), 32'hD502);
        hdr[0][3] = 2'b01;
        req[0][3] += 1;
        repeat (30) @(negedge clk);
        check("t4_err_still", 32'(err_a), 32'd1);
        check("t4_err_unit_kept", 32'(eu_a), 32'd1);
        check("t4_rd_2", 32'(r0(2)), 32'h8);
        check("t4_no_extra_words", 32'(n_w(0)), 32'd37);
        hdr[0][1] = 2'b11;
        hdr[0][3] = 2'b11;

        // 5: asynchronous reset in the middle of the payload
        apply_reset();
        req[0][0] += 1;
        wait_for(0, 1, 1, 10, "t5_first_rd");
        r = rt0(0);
        k = 0;
        while ((cyc < r + 103) && (k < 500)) begin @(negedge clk); k++; end
        check("t5_reached_sym100", 32'(cyc), 32'(r + 103));
        rst_n = 1'b0;
        #1;
        check("t5_async_wr_en", 32'(wa), 32'd0);
        check("t5_async_rd_en", 32'(rd_a), 32'd0);
        check("t5_async_dout", 32'(da), 32'd0);
        check("t5_async_state", 32'(dbg_a), 32'd0);
        repeat (2) @(negedge clk);
        mark();
        rst_n = 1'b1;
        req[0][0] += 1;
        c = cyc;
        wait_for(0, 1, 1, 10, "t5_rd_after_reset");
        check("t5_rd_unit0", 32'(r0(0)), 32'h1);
        check("t5_rd_latency", 32'(rt0(0) - c), 32'd1);
        wait_for(0, 0, 37, 400, "t5_word_count");
        check("t5_header", 32'(w0(0)), 32'hD500);
        check("t5_last_payload", 32'(w0(36)), 32'hE4E4);

        // 6: short packets on dut_b, alternating units 0/1
        apply_reset();
        req[1][0] += 2; req[1][1] += 2;
        for (int p = 0; p < 2; p++) begin
            exp_q.push_back(16'hD500); exp_q.push_back(16'hE4E4); exp_q.push_back(16'hE4E4);
            exp_q.push_back(16'hD501); exp_q.push_back(16'h3939); exp_q.push_back(16'h3939);
        end
        wait_for(1, 0, 12, 300, "t6_word_count");
        repeat (20) @(negedge clk);
        check("t6_words_total", 32'(n_w(1)), 32'd12);
        for (int j = 0; j < 12; j++) check($sformatf("t6_word_%0d", j), 32'(w1(j)), 32'(exp_q[j]));
        check("t6_gap_hdr_w1", 32'(t1(1) - t1(0)), 32'd8);
        check("t6_gap_w1_w2", 32'(t1(2) - t1(1)), 32'd8);
        check("t6_rd_0", 32'(r1(0)), 32'h1);
        check("t6_rd_1", 32'(r1(1)), 32'h2);
        check("t6_rd_2", 32'(r1(2)), 32'h1);
        check("t6_rd_3", 32'(r1(3)), 32'h2);
        check("t6_err_b", 32'(err_b), 32'd0);

        check("rd_en_onehot", 32'(bad_rd), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
